// File: rtl/phase_gen_pkg.sv
// phase_gen_pkg: shared types and phase-search helpers for phase_gen.
//   state_e     : FSM state encoding (IDLE, RUN)
//   sel_t       : result of a circular phase search (index, wrap, empty)
//   first_phase : lowest set bit of a mask
//   next_phase  : next set bit strictly above an index, circular, with wrap flag
//   is_last     : true when no enabled phase lies above the given index
// The helpers work on a PH_MAX-wide mask so that any N_PHASES up to 32 can
// zero-extend its mask into them.
package phase_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int PH_MAX   = 32;
    localparam int PH_IDX_W = 5;

    typedef struct packed {
        logic [PH_IDX_W-1:0] idx;
        logic                wrap;
        logic                empty;
    } sel_t;

    function automatic logic [PH_IDX_W-1:0] first_phase(input logic [PH_MAX-1:0] mask);
        logic [PH_IDX_W-1:0] idx;
        idx = {PH_IDX_W{1'b0}};
        // Descending scan so the lowest set bit is the last one written.
        for (int i = PH_MAX - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = PH_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic sel_t next_phase(input logic [PH_MAX-1:0]   mask,
                                        input logic [PH_IDX_W-1:0] cur_idx,
                                        input int                  n);
        sel_t res;
        // Default is the wrap case: back to the lowest enabled phase.
        res.idx   = first_phase(mask);
        res.wrap  = 1'b1;
        res.empty = (mask == {PH_MAX{1'b0}});
        for (int i = PH_MAX - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur_idx)) && (i < n)) begin
                res.idx  = PH_IDX_W'(i);
                res.wrap = 1'b0;
            end else begin
                res.idx  = res.idx;
            end
        end
        return res;
    endfunction

    function automatic logic is_last(input logic [PH_MAX-1:0]   mask,
                                     input logic [PH_IDX_W-1:0] cur_idx,
                                     input int                  n);
        sel_t res;
        res = next_phase(mask, cur_idx, n);
        return res.wrap;
    endfunction

endpackage

// File: rtl/phase_sel.sv
// phase_sel: combinational circular priority search over the phase mask.
//   mask       : enabled phases, bit i = phase i
//   cur_idx    : currently active phase index
//   next_idx   : next enabled phase strictly above cur_idx, circularly
//   wrap       : no enabled phase above cur_idx (search wrapped to the lowest)
//   mask_empty : mask has no bit set
module phase_sel
    import phase_gen_pkg::*;
#(
    parameter  int N_PHASES = 4,
    localparam int IDX_W    = $clog2(N_PHASES)
) (
    input  logic [N_PHASES-1:0] mask,
    input  logic [IDX_W-1:0]    cur_idx,
    output logic [IDX_W-1:0]    next_idx,
    output logic                wrap,
    output logic                mask_empty
);

    sel_t sel_s;

    // Widen to the package search width, then narrow the result back.
    always_comb begin
        sel_s      = next_phase(PH_MAX'(mask), PH_IDX_W'(cur_idx), N_PHASES);
        next_idx   = IDX_W'(sel_s.idx);
        wrap       = sel_s.wrap;
        mask_empty = sel_s.empty;
    end

endmodule

// File: rtl/phase_gen.sv
// phase_gen: multi-phase one-hot enable generator.
//   clk_in         : system clock, rising edge
//   rst_n_in       : asynchronous active-low reset
//   en_in          : block enable; low aborts a running sequence
//   mode_in        : 0 = continuous, 1 = single-shot
//   start_in       : single-shot trigger, only honoured in IDLE
//   hold_in        : phase length minus one, latched at each phase entry
//   mask_in        : phases in the rotation, latched at each phase entry
//   phase_out      : one-hot active phase, zero when idle
//   phase_idx_out  : active phase index, zero when idle
//   round_done_out : high on the last cycle of the highest phase of the round
//   busy_out       : high while running
// A phase's successor and its end-of-round status are both decided from the
// mask latched when that phase was entered, so round_done_out can be
// registered and still coincide with the final cycle of the round.
module phase_gen
    import phase_gen_pkg::*;
#(
    parameter  int N_PHASES = 4,
    parameter  int CNT_W    = 8,
    localparam int IDX_W    = $clog2(N_PHASES)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                en_in,
    input  logic                mode_in,
    input  logic                start_in,
    input  logic [CNT_W-1:0]    hold_in,
    input  logic [N_PHASES-1:0] mask_in,
    output logic [N_PHASES-1:0] phase_out,
    output logic [IDX_W-1:0]    phase_idx_out,
    output logic                round_done_out,
    output logic                busy_out
);

    localparam logic [N_PHASES-1:0] PHASE_LSB = {{(N_PHASES-1){1'b0}}, 1'b1};

    state_e              state_r;
    logic [N_PHASES-1:0] phase_r;
    logic [IDX_W-1:0]    idx_r;
    logic                round_done_r;
    logic                busy_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    hold_lat_r;
    logic [N_PHASES-1:0] mask_lat_r;

    logic [IDX_W-1:0]    sel_next_s;
    logic                sel_wrap_s;
    logic                lat_empty_s;
    logic                start_ok_s;
    logic [IDX_W-1:0]    entry_idx_s;
    logic                entry_last_s;
    logic                boundary_last_s;
    logic                mask_zero_s;
    logic                hold_zero_s;

    phase_sel #(
        .N_PHASES (N_PHASES)
    ) u_phase_sel (
        .mask       (mask_lat_r),
        .cur_idx    (idx_r),
        .next_idx   (sel_next_s),
        .wrap       (sel_wrap_s),
        .mask_empty (lat_empty_s)
    );

    // Start qualification and end-of-round flags for the phase about to be entered.
    always_comb begin
        mask_zero_s     = (mask_in == {N_PHASES{1'b0}});
        hold_zero_s     = (hold_in == {CNT_W{1'b0}});
        start_ok_s      = en_in && !mask_zero_s && (!mode_in || start_in);
        entry_idx_s     = IDX_W'(first_phase(PH_MAX'(mask_in)));
        entry_last_s    = is_last(PH_MAX'(mask_in), PH_IDX_W'(entry_idx_s), N_PHASES);
        boundary_last_s = is_last(PH_MAX'(mask_in), PH_IDX_W'(sel_next_s), N_PHASES);
    end

    // FSM, hold counter, latched programming and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r      <= IDLE;
            phase_r      <= {N_PHASES{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            round_done_r <= 1'b0;
            busy_r       <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            hold_lat_r   <= {CNT_W{1'b0}};
            mask_lat_r   <= {N_PHASES{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        state_r      <= RUN;
                        idx_r        <= entry_idx_s;
                        phase_r      <= PHASE_LSB << entry_idx_s;
                        mask_lat_r   <= mask_in;
                        hold_lat_r   <= hold_in;
                        cnt_r        <= {CNT_W{1'b0}};
                        busy_r       <= 1'b1;
                        // A one-cycle phase is its own last cycle.
                        round_done_r <= hold_zero_s && entry_last_s;
                    end else begin
                        state_r      <= IDLE;
                        phase_r      <= {N_PHASES{1'b0}};
                        idx_r        <= {IDX_W{1'b0}};
                        round_done_r <= 1'b0;
                        busy_r       <= 1'b0;
                        cnt_r        <= {CNT_W{1'b0}};
                    end
                end
                RUN: begin
                    if (!en_in) begin
                        state_r      <= IDLE;
                        phase_r      <= {N_PHASES{1'b0}};
                        idx_r        <= {IDX_W{1'b0}};
                        round_done_r <= 1'b0;
                        busy_r       <= 1'b0;
                        cnt_r        <= {CNT_W{1'b0}};
                    end else if (cnt_r != hold_lat_r) begin
                        cnt_r        <= cnt_r + CNT_W'(1);
                        // Raise the pulse as the counter enters its terminal value.
                        round_done_r <= ((cnt_r + CNT_W'(1)) == hold_lat_r) && sel_wrap_s;
                    end else if ((mode_in && sel_wrap_s) || mask_zero_s || lat_empty_s) begin
                        state_r      <= IDLE;
                        phase_r      <= {N_PHASES{1'b0}};
                        idx_r        <= {IDX_W{1'b0}};
                        round_done_r <= 1'b0;
                        busy_r       <= 1'b0;
                        cnt_r        <= {CNT_W{1'b0}};
                    end else begin
                        idx_r        <= sel_next_s;
                        phase_r      <= PHASE_LSB << sel_next_s;
                        mask_lat_r   <= mask_in;
                        hold_lat_r   <= hold_in;
                        cnt_r        <= {CNT_W{1'b0}};
                        round_done_r <= hold_zero_s && boundary_last_s;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    phase_r      <= {N_PHASES{1'b0}};
                    idx_r        <= {IDX_W{1'b0}};
                    round_done_r <= 1'b0;
                    busy_r       <= 1'b0;
                    cnt_r        <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign phase_out      = phase_r;
    assign phase_idx_out  = idx_r;
    assign round_done_out = round_done_r;
    assign busy_out       = busy_r;

endmodule
